// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;
  localparam int PC_INC          = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of assembled instruction words with their PCs.
// Entries are cleared on reset so the head reads as all-zero until the
// first push; a flush only rewinds the pointers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Byte-serial instruction fetch: reads IMEM one byte per cycle, assembles
// little-endian 32-bit words and queues them for IF/ID.
// Optional macro FETCH_BYPASS_EN: a word completing into an empty FIFO is
// presented on out_* in its arrival cycle instead of one cycle later.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc_next
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam int               RES_W     = CNT_W + 1;
  localparam logic [RES_W-1:0] DEPTH_R   = RES_W'(DEPTH);
  localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

  fetch_state_e state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [1:0]   byte_cnt_reg, byte_cnt_next;
  logic         resp_valid_reg;
  logic [1:0]   resp_idx_reg;
  logic [31:0]  resp_pc_reg;
  logic [2:0][7:0] lane_reg;

  logic [CNT_W-1:0] fifo_count;
  logic [RES_W-1:0] reserved_idle, reserved_word;
  fetch_entry_t     fifo_head, word_entry;
  logic             issue, word_done, fifo_empty, fifo_push, fifo_pop;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign issue    = (state_reg == ISSUE);
  assign mem_rd   = issue;
  assign mem_addr = issue ? fetch_pc_reg[ADDR_W-1:0] + ADDR_W'(byte_cnt_reg) : '0;

  // Slots already promised: queued words plus a word whose last byte is still returning.
  assign reserved_idle = RES_W'(fifo_count) + RES_W'(resp_valid_reg);
  assign reserved_word = RES_W'(fifo_count) + RES_W'(1);

  // Next-state logic; redirect overrides everything and restarts issue.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    byte_cnt_next = byte_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (reserved_idle < DEPTH_R) state_next = ISSUE;
      end
      ISSUE: begin
        byte_cnt_next = byte_cnt_reg + 2'd1;
        if (byte_cnt_reg == LAST_BYTE) begin
          fetch_pc_next = fetch_pc_reg + 32'(PC_INC);
          if (!(reserved_word < DEPTH_R)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      byte_cnt_next = 2'd0;
      state_next    = ISSUE;
    end
  end

  // Fetch FSM state, PC and byte counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      byte_cnt_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      byte_cnt_reg <= byte_cnt_next;
    end
  end

  // Response pipe tracks which lane the returning byte fills; redirect drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_reg <= 1'b0;
      resp_idx_reg   <= 2'd0;
      resp_pc_reg    <= 32'd0;
      lane_reg       <= '0;
    end else begin
      resp_valid_reg <= issue && !redirect;
      resp_idx_reg   <= byte_cnt_reg;
      if (issue && byte_cnt_reg == LAST_BYTE) resp_pc_reg <= fetch_pc_reg;
      if (redirect) begin
        lane_reg <= '0;
      end else if (resp_valid_reg) begin
        case (resp_idx_reg)
          2'd0:    lane_reg[0] <= mem_rdata;
          2'd1:    lane_reg[1] <= mem_rdata;
          2'd2:    lane_reg[2] <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  assign word_done        = resp_valid_reg && (resp_idx_reg == LAST_BYTE);
  assign word_entry.instr = {mem_rdata, lane_reg};
  assign word_entry.pc    = resp_pc_reg;
  assign fifo_empty       = (fifo_count == '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = word_done && fifo_empty;
  assign out_valid = !fifo_empty || bypass;
  assign out_instr = bypass ? word_entry.instr : fifo_head.instr;
  assign out_pc    = bypass ? word_entry.pc : fifo_head.pc;
  assign fifo_pop  = !fifo_empty && !stall && !redirect;
  assign fifo_push = word_done && !redirect && !(bypass && !stall);
`else
  assign out_valid = !fifo_empty;
  assign out_instr = fifo_head.instr;
  assign out_pc    = fifo_head.pc;
  assign fifo_pop  = out_valid && !stall && !redirect;
  assign fifo_push = word_done && !redirect;
`endif

  assign out_pc_next = out_valid ? out_pc + 32'(PC_INC) : 32'd0;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (word_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
